move_rx: RTL and testbench
==========================

Name: move_rx

Overview:
- Receive end of the MOVE step/direction link.
- Decodes an incoming asynchronous step/dir pulse stream into three things:
  - a 16-bit position feedback value;
  - a direction sign;
  - a measured step period in clk cycles.
- o_fid feeds the i_fid input of the transmit-side controller. Snapshots are taken on syncpulse, so TX and RX compare coherent values.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on i_step and i_dir (allowed range 2..3).
- TIMEOUT, 16'hFFFF, clk cycles with no step before the axis is declared stopped.
- MIN_PERIOD, 16'd4, step periods below this value set the overspeed flag.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_step  in  1  step pulse from the link; asynchronous; an event is its rising edge.
- i_dir  in  1  direction from the link; asynchronous; 0 = increment, 1 = decrement.
- syncpulse  in  1  one-cycle strobe that latches o_fid.
- i_clr  in  1  synchronous clear of position, flags and state.
- o_pos  out  16  live position counter.
- o_fid  out  16  position snapshot taken on syncpulse.
- o_sign  out  1  direction of the last accepted step.
- o_period  out  16  clk cycles between the last two same-direction steps.
- o_period_vld  out  1  one-cycle pulse when o_period updates.
- o_moving  out  1  high while in state RUN.
- o_overspeed  out  1  sticky flag; cleared by i_clr or reset.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - o_pos, o_fid and o_period are 0.
  - o_sign, o_period_vld, o_moving and o_overspeed are 0.
  - Synchronizer flops are 0, state is IDLE, cycle counter cnt is 0.
- Synchronization and latency:
  - i_step and i_dir each pass through SYNC_STAGES flops.
  - A step event is synced step = 1 while its previous value = 0.
  - Direction is taken from synced dir in the same cycle as the event.
  - With SYNC_STAGES=2, o_pos changes on the 3rd rising clk edge after i_step rises, provided setup is met.
  - i_dir must be stable for at least SYNC_STAGES+1 cycles before i_step rises.
- Position update:
  - On each event, o_pos increments by 1 if dir=0 or decrements by 1 if dir=1.
  - Arithmetic is modulo 2^16: 16'hFFFF+1 gives 0, and 0-1 gives 16'hFFFF, with no flag.
  - o_sign takes the value of dir on each event.
- Counter cnt (16 bits):
  - Increments every cycle in FIRST and RUN, saturating at TIMEOUT.
  - Reset to 0 on every event.
  - Held at 0 in IDLE.
- State machine:
  - IDLE: on an event, go to FIRST with cnt=0. o_period is not updated.
  - FIRST:
    - Event with the same dir as o_sign: o_period <= cnt+1, pulse o_period_vld, go to RUN.
    - Event with a different dir: stay in FIRST and restart cnt.
    - cnt == TIMEOUT: go to IDLE.
  - RUN:
    - Event with the same dir: o_period <= cnt+1, pulse o_period_vld.
    - Event with a different dir (reversal): go to FIRST. o_period holds its value and there is no vld pulse.
    - cnt == TIMEOUT with no event: go to IDLE and set o_period <= 0, with no vld pulse.
  - o_moving = 1 only in RUN.
- Overspeed: when a period is measured with cnt+1 < MIN_PERIOD, o_overspeed is set. It stays high until i_clr or reset. The period is still reported.
- Snapshot on syncpulse:
  - o_fid <= the position value being written into o_pos that cycle, so it includes a simultaneous step.
  - o_fid holds between syncpulses.
- Clear (i_clr=1):
  - Next cycle: o_pos=0, o_period=0, o_overspeed=0, state IDLE, cnt=0.
  - o_sign and o_fid hold their values.
  - A step event in the same cycle is discarded, because i_clr wins.
  - If syncpulse is also high in that cycle, o_fid <= 0.
- Reset during motion: immediate return to the reset values. The first step after release is an IDLE entry.

Decomposition:
- Shared package move_pkg holds:
  - the state enum {IDLE, FIRST, RUN};
  - POS_W=16 and PER_W=16;
  - the sign encoding constants DIR_INC=0 and DIR_DEC=1, which the transmit side also uses.
- One sub-module, move_sync_edge: a SYNC_STAGES synchronizer plus a rising-edge detector. It is instantiated for i_step, and i_dir uses the synchronizer path only.

Test Plan:
- Reset state: assert rst_n=0 mid-stream, then release → all outputs are 0 and state is IDLE. The first step after release gives o_pos=1 with no o_period_vld.
- Constant speed: 5 steps with dir=0, spaced 100 clk apart → o_pos=5, and o_period=100 with a vld pulse on steps 2 through 5. o_moving goes high after step 2.
- Wrap and reversal: preload by clearing, then 1 step with dir=1 → o_pos=16'hFFFF and o_sign=1. Then 2 steps with dir=0 → o_pos=16'h0001. The reversal step gives no vld and state returns to FIRST.
- Timeout: with TIMEOUT=200, stop steps while in RUN → after 200 cycles, o_moving=0, o_period=0 and state is IDLE.
- Overspeed and clear: 2 steps 3 clk apart → o_period=3 and o_overspeed=1. Then i_clr → o_overspeed=0 and o_pos=0. A step coinciding with i_clr is ignored.
- Snapshot: syncpulse in the same cycle as the internal step event at o_pos=9 with dir=0 → o_fid=10. A later syncpulse with no step keeps o_fid equal to o_pos.

Source files
------------

// File: rtl/move_pkg.sv
// Shared definitions for the MOVE step/direction link: state encoding,
// datapath widths and the direction sign encoding used by both link ends.
package move_pkg;

  localparam int POS_W = 16;
  localparam int PER_W = 16;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/move_sync_edge.sv
// Multi-flop synchronizer for a small bus of asynchronous inputs, with a
// rising-edge detector on bit 0 only (the other bits are level signals).
module move_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int W           = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rise
);

  logic [SYNC_STAGES-1:0][W-1:0] sync_reg;
  logic                          prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
      prev_reg <= sync_reg[SYNC_STAGES-1][0];
    end
  end

  assign q    = sync_reg[SYNC_STAGES-1];
  assign rise = q[0] & ~prev_reg;

endmodule

// File: rtl/move_rx.sv
// Receive end of the MOVE link: turns the synchronized step/dir stream into
// a live position, a coherent snapshot, a direction sign and a step period.
module move_rx
  import move_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [PER_W-1:0] TIMEOUT     = 16'hFFFF,
  parameter logic [PER_W-1:0] MIN_PERIOD  = 16'd4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_step,
  input  logic             i_dir,
  input  logic             syncpulse,
  input  logic             i_clr,
  output logic [POS_W-1:0] o_pos,
  output logic [POS_W-1:0] o_fid,
  output logic             o_sign,
  output logic [PER_W-1:0] o_period,
  output logic             o_period_vld,
  output logic             o_moving,
  output logic             o_overspeed
);

  state_t           state_reg, state_next;
  logic [PER_W-1:0] cnt_reg;
  logic [1:0]       sync_q;
  logic             step_rise;
  logic             dir_s;
  logic             evt;
  logic             same_dir;
  logic             timeout_hit;
  logic             measure;
  logic             period_clear;
  logic [PER_W:0]   per_meas;
  logic [POS_W-1:0] pos_next;

  move_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .W          (2)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    ({i_dir, i_step}),
    .q    (sync_q),
    .rise (step_rise)
  );

  // A clear in the same cycle swallows the step event.
  assign dir_s       = sync_q[1];
  assign evt         = step_rise & ~i_clr;
  assign same_dir    = (dir_s == o_sign);
  assign timeout_hit = (cnt_reg == TIMEOUT);
  assign per_meas    = {1'b0, cnt_reg} + (PER_W+1)'(1);

  always_comb begin
    pos_next = o_pos;
    if (i_clr) begin
      pos_next = '0;
    end else if (evt) begin
      pos_next = (dir_s == DIR_DEC) ? o_pos - POS_W'(1) : o_pos + POS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (i_clr) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:      if (evt) state_next = FIRST;
        FIRST,
        RUN: begin
          if (evt)              state_next = same_dir ? RUN : FIRST;
          else if (timeout_hit) state_next = IDLE;
        end
        default:   state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_moving     = (state_reg == RUN);
    measure      = evt & same_dir & (state_reg != IDLE);
    period_clear = ~evt & timeout_hit & (state_reg == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      o_pos        <= '0;
      o_fid        <= '0;
      o_sign       <= 1'b0;
      o_period     <= '0;
      o_period_vld <= 1'b0;
      o_overspeed  <= 1'b0;
    end else begin
      o_pos        <= pos_next;
      o_period_vld <= 1'b0;
      if (syncpulse) o_fid <= pos_next;
      if (i_clr) begin
        cnt_reg     <= '0;
        o_period    <= '0;
        o_overspeed <= 1'b0;
      end else begin
        if (evt) o_sign <= dir_s;
        if (evt || state_next == IDLE) cnt_reg <= '0;
        else if (!timeout_hit)         cnt_reg <= cnt_reg + PER_W'(1);
        if (measure) begin
          o_period     <= per_meas[PER_W-1:0];
          o_period_vld <= 1'b1;
          if (per_meas < {1'b0, MIN_PERIOD}) o_overspeed <= 1'b1;
        end else if (period_clear) begin
          o_period <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_move_rx.sv
// Self-checking bench for move_rx: directed scenarios plus random step trains,
// compared every cycle against a timestamp-based model of the link receiver.
module tb_move_rx;

  localparam logic [15:0] TO   = 16'd200;
  localparam int          MINP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_step = 1'b0;
  logic        i_dir = 1'b0;
  logic        syncpulse = 1'b0;
  logic        i_clr = 1'b0;
  logic [15:0] o_pos, o_fid, o_period;
  logic        o_sign, o_period_vld, o_moving, o_overspeed;

  move_rx #(
    .SYNC_STAGES(2),
    .TIMEOUT    (TO),
    .MIN_PERIOD (16'd4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_step      (i_step),
    .i_dir       (i_dir),
    .syncpulse   (syncpulse),
    .i_clr       (i_clr),
    .o_pos       (o_pos),
    .o_fid       (o_fid),
    .o_sign      (o_sign),
    .o_period    (o_period),
    .o_period_vld(o_period_vld),
    .o_moving    (o_moving),
    .o_overspeed (o_overspeed)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit rand_ctl = 0;

  // Model: pending step events (edge at which they land) and the receiver
  // state described as timestamps rather than a running counter.
  typedef struct {
    int   due;
    logic dir;
  } evt_t;
  evt_t        pend[$];
  int          m_mode;   // 0 idle, 1 first, 2 run
  int          m_last;
  logic [15:0] m_pos, m_fid, m_period;
  logic        m_sign, m_vld, m_ovs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_mode = 0; m_last = 0;
    m_pos = '0; m_fid = '0; m_period = '0;
    m_sign = 1'b0; m_vld = 1'b0; m_ovs = 1'b0;
  endtask

  task automatic model_edge();
    bit   ev;
    logic dir;
    int   per;
    ev = 0; dir = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      ev  = 1;
      dir = pend[0].dir;
      void'(pend.pop_front());
    end
    m_vld = 1'b0;
    if (i_clr) begin
      m_pos = '0; m_period = '0; m_ovs = 1'b0; m_mode = 0;
      if (syncpulse) m_fid = '0;
    end else begin
      if (ev) begin
        m_pos = dir ? m_pos - 16'd1 : m_pos + 16'd1;
        if (m_mode == 0) begin
          m_mode = 1;
        end else if (dir == m_sign) begin
          per      = cyc - m_last;
          m_period = 16'(per);
          m_vld    = 1'b1;
          if (per < MINP) m_ovs = 1'b1;
          m_mode   = 2;
        end else begin
          m_mode = 1;
        end
        m_last = cyc;
        m_sign = dir;
      end else if (m_mode != 0 && (cyc - m_last) > int'(TO)) begin
        if (m_mode == 2) m_period = '0;
        m_mode = 0;
      end
      if (syncpulse) m_fid = m_pos;
    end
  endtask

  task automatic compare_all();
    check("pos",       32'(o_pos),        32'(m_pos));
    check("fid",       32'(o_fid),        32'(m_fid));
    check("sign",      32'(o_sign),       32'(m_sign));
    check("period",    32'(o_period),     32'(m_period));
    check("vld",       32'(o_period_vld), 32'(m_vld));
    check("moving",    32'(o_moving),     32'(m_mode == 2));
    check("overspeed", 32'(o_overspeed),  32'(m_ovs));
  endtask

  task automatic tick();
    if (rand_ctl) begin
      syncpulse = ($urandom_range(0, 15) == 0);
      i_clr     = ($urandom_range(0, 79) == 0);
    end
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_step(input logic v);
    if (v && !i_step && rst_n) pend.push_back('{due: cyc + 3, dir: i_dir});
    i_step = v;
  endtask

  task automatic train(input logic dir, input int n, input int gap);
    if (i_dir != dir) begin
      i_dir = dir;
      repeat (3) tick();
    end
    repeat (n) begin
      set_step(1'b1);
      tick();
      set_step(1'b0);
      repeat (gap - 1) tick();
    end
    $display("train dir=%0d n=%0d gap=%0d pos=%h period=%0d moving=%0d",
             dir, n, gap, o_pos, o_period, o_moving);
  endtask

  task automatic clear();
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    tick();
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_pos", 32'(o_pos), 32'd0);

    // First step after reset is an IDLE entry: position moves, no period
    train(1'b0, 1, 10);
    check("first_pos", 32'(o_pos), 32'd1);

    // Constant speed
    clear();
    train(1'b0, 5, 100);
    check("cs_pos", 32'(o_pos), 32'd5);
    check("cs_period", 32'(o_period), 32'd100);
    check("cs_moving", 32'(o_moving), 32'd1);

    // Reset during motion
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    train(1'b0, 1, 10);
    check("rst_first_pos", 32'(o_pos), 32'd1);

    // Wrap and reversal
    clear();
    train(1'b1, 1, 20);
    check("wrap_pos", 32'(o_pos), 32'hFFFF);
    check("wrap_sign", 32'(o_sign), 32'd1);
    train(1'b0, 2, 20);
    check("rev_pos", 32'(o_pos), 32'h0001);

    // Timeout from RUN
    clear();
    train(1'b0, 2, 20);
    repeat (250) tick();
    check("to_moving", 32'(o_moving), 32'd0);
    check("to_period", 32'(o_period), 32'd0);

    // Overspeed, then a clear that swallows a coincident step
    clear();
    train(1'b0, 2, 3);
    check("ovs_period", 32'(o_period), 32'd3);
    check("ovs_flag", 32'(o_overspeed), 32'd1);
    set_step(1'b1); tick();
    set_step(1'b0); tick();
    i_clr = 1'b1; tick();
    i_clr = 1'b0;
    repeat (3) tick();
    check("clr_ovs", 32'(o_overspeed), 32'd0);
    check("clr_pos", 32'(o_pos), 32'd0);

    // Snapshot coincident with a step at position 9
    clear();
    train(1'b0, 9, 10);
    set_step(1'b1); tick();
    set_step(1'b0); tick();
    syncpulse = 1'b1; tick();
    syncpulse = 1'b0;
    check("snap_step", 32'(o_fid), 32'd10);
    repeat (5) tick();
    syncpulse = 1'b1; tick();
    syncpulse = 1'b0;
    check("snap_hold", 32'(o_fid), 32'(m_pos));

    // Random trains with random snapshots and clears
    rand_ctl = 1;
    for (int t = 0; t < 30; t++) begin
      train(logic'($urandom_range(0, 1)), int'($urandom_range(1, 3)), int'($urandom_range(2, 230)));
    end
    rand_ctl  = 0;
    syncpulse = 1'b0;
    i_clr     = 1'b0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
